// File: rtl/thor2022_bus_fault_pkg.sv
// Shared definitions for the bus fault unit.
// Contents: fault cause codes, register offsets, controller state encoding,
// and a helper that picks the winning cause among simultaneous fault events.
package thor2022_bus_fault_pkg;

  // Fault cause codes. A lower code wins when several events coincide.
  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] FC_PAGE = 3'd1;
  localparam logic [2:0] FC_PRV  = 3'd2;
  localparam logic [2:0] FC_EXV  = 3'd3;
  localparam logic [2:0] FC_WRV  = 3'd4;
  localparam logic [2:0] FC_RDV  = 3'd5;
  localparam logic [2:0] FC_TMO  = 3'd6;
  localparam logic [2:0] FC_BERR = 3'd7;

  // Register offsets, taken from byte address bits 4:3.
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_FADR   = 2'd1;
  localparam logic [1:0] REG_TLIMIT = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Bit n of ev set means an event with cause code n happened this cycle.
  // Scanning from the top down leaves the lowest active code as the result.
  function automatic logic [2:0] fc_pick(input logic [7:1] ev);
    fc_pick = FC_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (ev[i]) fc_pick = 3'(i);
    end
  endfunction

endpackage

// File: rtl/thor2022_bus_timeout_ctr.sv
// Bus-cycle timeout counter.
// Counts clk cycles while not cleared, saturating at 16'hFFFF, and flags
// when the count reaches limit-1. A limit of zero never flags.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   i_clr     : clear the count to zero this cycle
//   i_limit   : timeout limit in cycles (0 disables)
//   o_hit     : current count equals limit-1
module thor2022_bus_timeout_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic [15:0] i_limit,
  output logic        o_hit
);

  logic [15:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (r_count != 16'hFFFF) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_hit = (i_limit != 16'd0) && (r_count == i_limit - 16'd1);

endmodule

// File: rtl/thor2022_bus_fault_unit.sv
// Bus fault unit between the MMU physical-bus master and the system bus.
// Passes translated cycles through, aborts hung cycles with a synthetic ack,
// records the first fault (cause, address, direction) and raises an irq.
// Ports:
//   s_*        : cycle from the MMU, violation flags, page-fault pulse, ack back
//   m_*        : cycle to the system bus, its ack and error
//   err_o      : one-cycle abort indication to the CPU
//   irq_o      : registered FVALID & IE
//   cs_i..dat_o: register port (STATUS, FADR, TLIMIT), ack one cycle later
module thor2022_bus_fault_unit
  import thor2022_bus_fault_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_DEF = 16'd1023,
  parameter int          CAUSE_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_cyc_i,
  input  logic        s_we_i,
  input  logic [7:0]  s_sel_i,
  input  logic [2:0]  s_cti_i,
  input  logic [1:0]  s_bte_i,
  input  logic [31:0] s_padr_i,
  input  logic        s_exv_i,
  input  logic        s_rdv_i,
  input  logic        s_wrv_i,
  input  logic        s_prv_i,
  input  logic        s_page_fault_i,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  output logic [7:0]  m_sel_o,
  output logic [2:0]  m_cti_o,
  output logic [1:0]  m_bte_o,
  output logic [31:0] m_padr_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        err_o,
  output logic        irq_o,
  input  logic        cs_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [63:0] dat_i,
  output logic        ack_o,
  output logic [63:0] dat_o
);

  state_t r_state, w_state_nxt;
  logic   w_viol, w_hit, w_tmo, w_abort;

  logic [7:1]         w_ev;
  logic               w_fault;
  logic               r_fvalid, r_ovf, r_fwe, r_ie, r_irq, r_ack;
  logic [CAUSE_W-1:0] r_cause;
  logic [31:0]        r_fadr;
  logic [15:0]        r_limit;
  logic [63:0]        r_dat, w_rdata;
  logic               w_acc, w_wr_status, w_wr_tlimit, w_fv_kept;
  logic               w_unused;

  assign w_viol = s_exv_i | s_rdv_i | s_wrv_i | s_prv_i;

  // Pass-through to the system bus.
  assign m_we_o   = s_we_i;
  assign m_sel_o  = s_sel_i;
  assign m_cti_o  = s_cti_i;
  assign m_bte_o  = s_bte_i;
  assign m_padr_o = s_padr_i;
  assign m_cyc_o  = s_cyc_i & (r_state != ST_ABORT) & ~w_viol;

  // The counter runs only in BUSY and restarts on each ack, so every burst
  // beat gets its own timeout window.
  thor2022_bus_timeout_ctr u_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_clr   ((r_state != ST_BUSY) | m_ack_i),
    .i_limit (r_limit),
    .o_hit   (w_hit)
  );

  // A beat acked in the same cycle the limit is reached has completed.
  assign w_tmo = w_hit & ~m_ack_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE:  if (s_cyc_i) w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (!s_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmo || m_err_i || w_viol) begin
          w_state_nxt = ST_ABORT;
          w_abort     = 1'b1;
        end
      end
      ST_ABORT: if (!s_cyc_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_ack_o = (m_ack_i & m_cyc_o) | w_abort;
  assign err_o   = w_abort;

  // Fault events; violation flags only count on entry to ABORT.
  always_comb begin
    w_ev          = '0;
    w_ev[FC_PAGE] = s_page_fault_i;
    w_ev[FC_PRV]  = w_abort & s_prv_i;
    w_ev[FC_EXV]  = w_abort & s_exv_i;
    w_ev[FC_WRV]  = w_abort & s_wrv_i;
    w_ev[FC_RDV]  = w_abort & s_rdv_i;
    w_ev[FC_TMO]  = w_abort & w_tmo;
    w_ev[FC_BERR] = w_abort & m_err_i;
  end
  assign w_fault = |w_ev;

  // Register port: one ack per access, even if the strobe is held.
  assign w_acc       = cs_i & cyc_i & stb_i & ~r_ack;
  assign w_wr_status = w_acc & we_i & (adr_i == REG_STATUS);
  assign w_wr_tlimit = w_acc & we_i & (adr_i == REG_TLIMIT);

  // FVALID after any W1C this cycle; a fault arriving now is judged against
  // it, so a fault coinciding with a clear is captured fresh.
  assign w_fv_kept = r_fvalid & ~(w_wr_status & dat_i[0]);

  always_comb begin
    w_rdata = '0;
    case (adr_i)
      REG_STATUS: w_rdata = {55'd0, r_ie, 2'b00, r_fwe, 3'(r_cause), r_ovf, r_fvalid};
      REG_FADR:   w_rdata = {32'd0, r_fadr};
      REG_TLIMIT: w_rdata = {48'd0, r_limit};
      REG_RSVD:   w_rdata = '0;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_cause  <= '0;
      r_fadr   <= '0;
      r_fwe    <= 1'b0;
      r_ie     <= 1'b0;
      r_limit  <= TIMEOUT_DEF;
      r_irq    <= 1'b0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
    end else begin
      if (w_fault && !w_fv_kept) begin
        r_fvalid <= 1'b1;
        r_cause  <= CAUSE_W'(fc_pick(w_ev));
        r_fadr   <= s_padr_i;
        r_fwe    <= s_we_i;
      end else begin
        r_fvalid <= w_fv_kept;
      end
      r_ovf <= (r_ovf & ~(w_wr_status & dat_i[1])) | (w_fault & w_fv_kept);
      if (w_wr_status) r_ie    <= dat_i[8];
      if (w_wr_tlimit) r_limit <= dat_i[15:0];
      r_irq <= r_fvalid & r_ie;
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : '0;
    end
  end

  assign irq_o = r_irq;
  assign ack_o = r_ack;
  assign dat_o = r_dat;

  assign w_unused = ^dat_i[63:16];

endmodule
